// File: rtl/mos6502_pkg.sv
// Shared definitions for the 6502 ALU: one-hot op-select bit positions and
// the decimal-adjust constants.
package mos6502_pkg;
  localparam int SEL_SUM  = 0;
  localparam int SEL_SUB  = 1;
  localparam int SEL_AND  = 2;
  localparam int SEL_EOR  = 3;
  localparam int SEL_OR   = 4;
  localparam int SEL_SHR  = 5;
  localparam int SEL_SHCR = 6;
  localparam int NUM_OPS  = 7;

  localparam logic [3:0] BCD_ADJ   = 4'd6;
  localparam logic [3:0] BCD_LIMIT = 4'd9;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
  } bcd_out_t;
endpackage

// File: rtl/mos6502_bcd_adj.sv
// Combinational nibble-wise decimal adjust. Add re-derives nibble sums from the
// operands; subtract corrects the binary difference by nibble borrows.
module mos6502_bcd_adj
  import mos6502_pkg::*;
(
  input  logic       i_sub,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  input  logic [7:0] i_bin_res,
  input  logic       i_bin_cout,
  output bcd_out_t   o_out
);
  logic [4:0] w_lo_add, w_hi_add, w_lo_sub;
  logic       w_lo_c, w_hi_c, w_lo_borrow;
  logic [3:0] w_lo, w_hi;

  always_comb begin
    w_lo_add    = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_cin};
    w_lo_c      = w_lo_add > {1'b0, BCD_LIMIT};
    w_hi_add    = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + {4'b0, w_lo_c};
    w_hi_c      = w_hi_add > {1'b0, BCD_LIMIT};
    // No carry out of the low nibble of A+~B+cin means that nibble borrowed.
    w_lo_sub    = {1'b0, i_a[3:0]} + {1'b0, ~i_b[3:0]} + {4'b0, i_cin};
    w_lo_borrow = ~w_lo_sub[4];
    w_lo        = '0;
    w_hi        = '0;
    o_out       = '0;
    if (i_sub) begin
      w_lo      = i_bin_res[3:0] - (w_lo_borrow ? BCD_ADJ : 4'd0);
      w_hi      = i_bin_res[7:4] - (i_bin_cout ? 4'd0 : BCD_ADJ);
      o_out.c   = i_bin_cout;
    end else begin
      w_lo      = w_lo_add[3:0] + (w_lo_c ? BCD_ADJ : 4'd0);
      w_hi      = w_hi_add[3:0] + (w_hi_c ? BCD_ADJ : 4'd0);
      o_out.c   = w_hi_c;
    end
    o_out.res = {w_hi, w_lo};
  end
endmodule

// File: rtl/mos6502_alu.sv
// Registered 6502 ALU: one op per clock into the adder-hold register, with the
// held result driven onto the ADL and SB buses under separate enables.
module mos6502_alu
  import mos6502_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic             cin,
  input  logic             sums,
  input  logic             subs,
  input  logic             ands,
  input  logic             eors,
  input  logic             ors,
  input  logic             shftr,
  input  logic             shftcr,
  input  logic             decEn,
  input  logic             adloa,
  input  logic             sboa,
  output logic [WIDTH-1:0] adl,
  output logic [WIDTH-1:0] sb,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             neg
);
  logic [NUM_OPS-1:0] w_sel;
  logic               w_is_sub, w_load, w_bin_v;
  logic [WIDTH-1:0]   w_b_eff, w_res, w_dec_res;
  logic [WIDTH:0]     w_bin;
  logic               w_c, w_v, w_dec_c;
  logic [WIDTH-1:0]   r_res;
  logic               r_c, r_z, r_v, r_n;

  assign w_sel[SEL_SUM]  = sums;
  assign w_sel[SEL_SUB]  = subs;
  assign w_sel[SEL_AND]  = ands;
  assign w_sel[SEL_EOR]  = eors;
  assign w_sel[SEL_OR]   = ors;
  assign w_sel[SEL_SHR]  = shftr;
  assign w_sel[SEL_SHCR] = shftcr;
  assign w_load          = |w_sel;

  // One adder serves both add and subtract; sums wins when both are set.
  assign w_is_sub = ~w_sel[SEL_SUM] & w_sel[SEL_SUB];
  assign w_b_eff  = w_is_sub ? ~bIn : bIn;
  assign w_bin    = {1'b0, aIn} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};
  assign w_bin_v  = (aIn[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_bin[WIDTH-1] != aIn[WIDTH-1]);

  generate
    if (WIDTH == 8) begin : g_bcd
      bcd_out_t w_bcd;
      mos6502_bcd_adj u_bcd_adj (
        .i_sub      (w_is_sub),
        .i_a        (aIn),
        .i_b        (bIn),
        .i_cin      (cin),
        .i_bin_res  (w_bin[7:0]),
        .i_bin_cout (w_bin[8]),
        .o_out      (w_bcd)
      );
      assign w_dec_res = w_bcd.res;
      assign w_dec_c   = w_bcd.c;
    end else begin : g_no_bcd
      assign w_dec_res = w_bin[WIDTH-1:0];
      assign w_dec_c   = w_bin[WIDTH];
    end
  endgenerate

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    if (w_sel[SEL_SUM] || w_sel[SEL_SUB]) begin
      w_res = decEn ? w_dec_res : w_bin[WIDTH-1:0];
      w_c   = decEn ? w_dec_c   : w_bin[WIDTH];
      w_v   = w_bin_v;
    end else if (w_sel[SEL_AND]) begin
      w_res = aIn & bIn;
    end else if (w_sel[SEL_EOR]) begin
      w_res = aIn ^ bIn;
    end else if (w_sel[SEL_OR]) begin
      w_res = aIn | bIn;
    end else if (w_sel[SEL_SHR]) begin
      w_res = {1'b0, aIn[WIDTH-1:1]};
      w_c   = aIn[0];
    end else if (w_sel[SEL_SHCR]) begin
      w_res = {cin, aIn[WIDTH-1:1]};
      w_c   = aIn[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res <= '0;
      r_c   <= 1'b0;
      r_z   <= 1'b0;
      r_v   <= 1'b0;
      r_n   <= 1'b0;
    end else if (w_load) begin
      r_res <= w_res;
      r_c   <= w_c;
      r_z   <= (w_res == '0);
      r_v   <= w_v;
      r_n   <= w_res[WIDTH-1];
    end
  end

  assign adl      = adloa ? r_res : {WIDTH{1'bz}};
  assign sb       = sboa  ? r_res : {WIDTH{1'bz}};
  assign cout     = r_c;
  assign zero     = r_z;
  assign overflow = r_v;
  assign neg      = r_n;
endmodule

// File: tb/tb_mos6502_alu.sv
// Bench for mos6502_alu: integer-arithmetic reference model checked every
// negedge, plus hand-computed literal expectations along the directed sequence.
module tb_mos6502_alu;
  localparam int S_SUM = 0, S_SUB = 1, S_AND = 2, S_EOR = 3, S_OR = 4, S_SHR = 5, S_SHCR = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] aIn, bIn;
  logic       cin, sums, subs, ands, eors, ors, shftr, shftcr, decEn, adloa, sboa;
  wire  [7:0] adl, sb;
  wire        cout, zero, overflow, neg;

  int   n_chk = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;
  logic [11:0] m_st;  // {res[7:0], c, z, v, n}

  mos6502_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .aIn(aIn), .bIn(bIn), .cin(cin),
    .sums(sums), .subs(subs), .ands(ands), .eors(eors), .ors(ors),
    .shftr(shftr), .shftcr(shftcr), .decEn(decEn), .adloa(adloa), .sboa(sboa),
    .adl(adl), .sb(sb), .cout(cout), .zero(zero), .overflow(overflow), .neg(neg)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model_op(input logic [6:0] sel, input int a, input int b,
                                           input int ci, input logic dec);
    int r, c, v, d, lo, hi, lc, s;
    r = 0; c = 0; v = 0;
    if (sel[S_SUM]) begin
      s = a + b + ci;
      r = s % 256; c = (s > 255);
      v = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
      if (dec) begin
        lo = (a % 16) + (b % 16) + ci;
        lc = (lo > 9);
        if (lc != 0) lo = lo + 6;
        hi = (a / 16) + (b / 16) + lc;
        c  = (hi > 9);
        if (c != 0) hi = hi + 6;
        r = (hi % 16) * 16 + (lo % 16);
      end
    end else if (sel[S_SUB]) begin
      d = a - b - (1 - ci);
      c = (d >= 0);
      r = (d + 256) % 256;
      v = ((a >= 128) == (b < 128)) && ((r >= 128) != (a >= 128));
      if (dec) begin
        lo = r % 16; hi = r / 16;
        if ((a % 16) - (b % 16) - (1 - ci) < 0) lo = (lo + 10) % 16;
        if (c == 0) hi = (hi + 10) % 16;
        r = hi * 16 + lo;
      end
    end else if (sel[S_AND]) r = a & b;
    else if (sel[S_EOR])     r = a ^ b;
    else if (sel[S_OR])      r = a | b;
    else if (sel[S_SHR])     begin r = a / 2;              c = a % 2; end
    else if (sel[S_SHCR])    begin r = a / 2 + 128 * ci;   c = a % 2; end
    return {r[7:0], c[0], (r == 0), v[0], (r >= 128)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_st <= '0;
    else if (|{shftcr, shftr, ors, eors, ands, subs, sums})
      m_st <= model_op({shftcr, shftr, ors, eors, ands, subs, sums},
                       int'(aIn), int'(bIn), int'(cin), decEn);
  end

  function automatic logic bus_ok(input logic [7:0] got, input logic en, input logic [7:0] exp);
    // A released bus reads as z on four-state simulators and as 0 on two-state ones.
    if (en) return got === exp;
    return (got === 8'hzz) || (got === 8'h00);
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic chk_bus(input string name, input logic [7:0] got, input logic en, input logic [7:0] exp);
    n_chk++;
    if (bus_ok(got, en, exp)) n_pass++;
    else $display("FAIL %s: got %h, expected %h (enable %0b) at %0t", name, got, exp, en, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model flags", {4'b0, 4'b0, 4'b0, cout, zero, overflow, neg}, {8'b0, m_st[3:0]});
      chk_bus("model adl", adl, adloa, m_st[11:4]);
      chk_bus("model sb", sb, sboa, m_st[11:4]);
    end
  end

  task automatic step(input logic [6:0] sel, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic dec);
    @(negedge clk); #2;
    aIn = a; bIn = b; cin = c; decEn = dec;
    {shftcr, shftr, ors, eors, ands, subs, sums} = sel;
    @(posedge clk); #1;
    {shftcr, shftr, ors, eors, ands, subs, sums} = '0;
  endtask

  // Literal expectation: held result on adl (adloa=1) and flags {c,z,v,n}.
  task automatic expect_lit(input string name, input logic [7:0] res, input logic [3:0] f);
    chk(name, {adl, cout, zero, overflow, neg}, {res, f});
  endtask

  logic [7:0] tv_a [4];
  logic [7:0] tv_b [4];

  initial begin
    reset = 1'b0; aIn = 8'hFF; bIn = 8'h01; cin = 1'b0; decEn = 1'b0;
    {shftcr, shftr, ors, eors, ands, subs, sums} = '0;
    adloa = 1'b1; sboa = 1'b0;
    repeat (2) @(negedge clk);
    #1 expect_lit("reset state", 8'h00, 4'b0000);
    chk_en = 1'b1;
    @(negedge clk); #2 reset = 1'b1;

    step(7'b0000001, 8'hFF, 8'h01, 1'b0, 1'b0); expect_lit("add FF+01", 8'h00, 4'b1100);
    step(7'b0000010, 8'hFF, 8'h01, 1'b0, 1'b0); expect_lit("sub FF-01", 8'hFD, 4'b1001);
    step(7'b0000100, 8'hFF, 8'h01, 1'b0, 1'b0); expect_lit("and", 8'h01, 4'b0000);
    step(7'b0001000, 8'hFF, 8'h01, 1'b0, 1'b0); expect_lit("eor", 8'hFE, 4'b0001);
    step(7'b0010000, 8'hFF, 8'h01, 1'b0, 1'b0); expect_lit("or", 8'hFF, 4'b0001);
    step(7'b0100000, 8'hFF, 8'h01, 1'b0, 1'b0); expect_lit("shr", 8'h7F, 4'b1000);
    step(7'b1000000, 8'hFF, 8'h01, 1'b1, 1'b0); expect_lit("rotr", 8'hFF, 4'b1001);
    step(7'b0000001, 8'h09, 8'h01, 1'b0, 1'b1); expect_lit("dec add 09+01", 8'h10, 4'b0000);
    step(7'b0000001, 8'h99, 8'h01, 1'b0, 1'b1); expect_lit("dec add 99+01", 8'h00, 4'b1100);
    step(7'b0000010, 8'h10, 8'h01, 1'b1, 1'b1); expect_lit("dec sub 10-01", 8'h09, 4'b1000);
    step(7'b0000101, 8'h50, 8'h50, 1'b0, 1'b0); expect_lit("priority add>and", 8'hA0, 4'b0011);
    step(7'b0000010, 8'h80, 8'h01, 1'b1, 1'b0); expect_lit("sub overflow", 8'h7F, 4'b1010);

    @(negedge clk); #2 adloa = 1'b0; sboa = 1'b1;
    #1 chk_bus("adl released", adl, 1'b0, 8'h7F);
    chk("sb drives", {4'b0, sb}, {4'b0, 8'h7F});

    aIn = 8'h12; bIn = 8'h34; cin = 1'b1; decEn = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("hold", {sb, cout, zero, overflow, neg}, {8'h7F, 4'b1010});

    adloa = 1'b1;
    #1 chk("both buses", {adl, sb}, {8'h7F, 8'h7F});

    @(posedge clk); #3 reset = 1'b0;
    #1 chk("async reset", {adl, sb, cout, zero, overflow, neg}, {8'h00, 8'h00, 4'b0000});
    @(negedge clk); #2 reset = 1'b1;

    tv_a[0] = 8'hA5; tv_b[0] = 8'h3C;
    tv_a[1] = 8'h7F; tv_b[1] = 8'h01;
    tv_a[2] = 8'h45; tv_b[2] = 8'h38;
    tv_a[3] = 8'h00; tv_b[3] = 8'hFF;
    for (int v = 0; v < 4; v++)
      for (int op = 0; op < 7; op++)
        for (int d = 0; d < 2; d++)
          step(7'(1 << op), tv_a[v], tv_b[v], logic'(v[0] ^ op[0]), logic'(d));

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
